// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback
// requesters, with a pending-write scoreboard for read-after-write hazard stalls.
module regfile_wr_arbiter #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int ZR_ADDR = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [ADDR_W-1:0]        q1_addr,
  input  logic [ADDR_W-1:0]        q2_addr,
  output logic                     haz1,
  output logic                     haz2,
  output logic                     we3,
  output logic [ADDR_W-1:0]        wa3,
  output logic [DATA_W-1:0]        wd3,
  output logic [(2**ADDR_W)-2:0]   pending
);

  localparam int NREG = (2**ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZR_ADDR);

  typedef enum logic {GNT_REQ0 = 1'b0, GNT_REQ1 = 1'b1} gnt_e;

  gnt_e               last_grant;
  logic               gnt0, gnt1, hs;
  logic [ADDR_W-1:0]  hs_addr;
  logic [DATA_W-1:0]  hs_data;
  logic [NREG-1:0]    pending_nxt;

  // On contention the requester that did not win last time is favoured.
  always_comb begin
    gnt0    = req0_valid && (!req1_valid || (last_grant == GNT_REQ1));
    gnt1    = req1_valid && (!req0_valid || (last_grant == GNT_REQ0));
    hs      = gnt0 || gnt1;
    hs_addr = gnt0 ? req0_addr : req1_addr;
    hs_data = gnt0 ? req0_data : req1_data;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Claim is applied after the clear so a new producer keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (hs && (hs_addr == ADDR_W'(i)) && (hs_addr != ZR))
        pending_nxt[i] = 1'b0;
      if (claim_valid && (claim_addr == ADDR_W'(i)) && (claim_addr != ZR))
        pending_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if ((q1_addr == ADDR_W'(i)) && (q1_addr != ZR) && pending[i]) haz1 = 1'b1;
      if ((q2_addr == ADDR_W'(i)) && (q2_addr != ZR) && pending[i]) haz2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GNT_REQ1;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      pending    <= '0;
    end else begin
      pending <= pending_nxt;
      we3     <= hs && (hs_addr != ZR);
      if (hs) begin
        last_grant <= gnt1 ? GNT_REQ1 : GNT_REQ0;
      end
      if (hs && (hs_addr != ZR)) begin
        wa3 <= hs_addr;
        wd3 <= hs_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a reference model predicts grants,
// hazards and the registered write port; a monitor compares after each edge.
module tb_regfile_wr_arbiter;

  logic        clk, reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, claim_addr, q1_addr, q2_addr, wa3;
  logic [63:0] req0_data, req1_data, wd3;
  logic        claim_valid, haz1, haz2, we3;
  logic [30:0] pending;

  regfile_wr_arbiter #(.DATA_W(64), .ADDR_W(5), .ZR_ADDR(31)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .haz1(haz1), .haz2(haz2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        known;
    logic [30:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int          m_last;
  bit          m_pend[32];
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic        m_known;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_wa    = '0;
    m_wd    = '0;
    m_known = 1'b1;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  function automatic logic [30:0] pend_vec();
    logic [30:0] v;
    for (int i = 0; i < 31; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock of stimulus: drive, check combinational outputs, advance model,
  // queue the expected post-edge state. g returns 0 none, 1 req0, 2 req1.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                      input logic cv, input logic [4:0] ca,
                      input logic [4:0] qa, input logic [4:0] qb, output int g);
    exp_t e;
    int   win;
    logic [4:0] wa;
    @(posedge clk);
    #2;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    claim_valid = cv; claim_addr = ca; q1_addr = qa; q2_addr = qb;
    #1;
    if (v0 && v1) win = 1 - m_last;
    else if (v0)  win = 0;
    else if (v1)  win = 1;
    else          win = -1;
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, win == 0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, win == 1});
    chk("haz1", {63'd0, haz1}, {63'd0, (qa != 5'd31) && m_pend[qa]});
    chk("haz2", {63'd0, haz2}, {63'd0, (qb != 5'd31) && m_pend[qb]});
    e.we = 1'b0;
    if (win >= 0) begin
      m_last = win;
      wa = (win == 0) ? a0 : a1;
      if (wa != 5'd31) begin
        e.we    = 1'b1;
        m_wa    = wa;
        m_wd    = (win == 0) ? d0 : d1;
        m_known = 1'b1;
        m_pend[wa] = 1'b0;
      end else begin
        m_known = 1'b0;
      end
    end
    if (cv && ca != 5'd31) m_pend[ca] = 1'b1;
    e.wa = m_wa; e.wd = m_wd; e.known = m_known; e.pend = pend_vec();
    exp_q.push_back(e);
    g = win + 1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we3", {63'd0, we3}, {63'd0, e.we});
      if (e.known) begin
        chk("wa3", {59'd0, wa3}, {59'd0, e.wa});
        chk("wd3", wd3, e.wd);
      end
      chk("pending", {33'd0, pending}, {33'd0, e.pend});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic        r0v, r1v;
    logic [4:0]  r0a, r1a, ca, qa, qb;
    logic [63:0] r0d, r1d;
    logic        cv;

    reset = 1'b0;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    claim_valid = 0; claim_addr = '0; q1_addr = '0; q2_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", {63'd0, we3}, 64'd0);
    chk("rst_wa3", {59'd0, wa3}, 64'd0);
    chk("rst_wd3", wd3, 64'd0);
    chk("rst_pending", {33'd0, pending}, 64'd0);
    chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // single requester, then idle
    step(1, 5'd5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, g);
    chk("single_grant", g, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    // zero register via req1; this also makes req0 the favoured one next
    step(0, 0, 0, 1, 5'd31, 64'h1234, 0, 0, 0, 0, g);
    chk("zr_grant", g, 2);
    // continuous contention
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd1, 64'h100 + i, 1, 5'd2, 64'h200 + i, 0, 0, 0, 0, g);
      chk("contention_grant", g, (i % 2 == 0) ? 1 : 2);
    end
    // scoreboard
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, g);
    step(1, 5'd7, 64'h77, 0, 0, 0, 1, 5'd7, 5'd7, 5'd3, g);
    step(1, 5'd7, 64'h78, 0, 0, 0, 0, 0, 5'd7, 5'd7, g);
    step(0, 0, 0, 0, 0, 0, 1, 5'd31, 5'd7, 5'd31, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd31, g);
    chk("zr_claim_pending", {33'd0, pending}, 64'd0);

    // randomized traffic honouring hold-until-handshake
    r0v = 0; r1v = 0; r0a = 0; r1a = 0; r0d = 0; r1d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!r0v && $urandom_range(0, 3) != 0) begin
        r0v = 1; r0a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        r0d = {$urandom, $urandom};
      end
      if (!r1v && $urandom_range(0, 3) != 0) begin
        r1v = 1; r1a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        r1d = {$urandom, $urandom};
      end
      cv = ($urandom_range(0, 1) == 1);
      ca = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      qa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      qb = 5'($urandom_range(0, 31));
      step(r0v, r0a, r0d, r1v, r1a, r1d, cv, ca, qa, qb, g);
      if (g == 1) r0v = 0;
      if (g == 2) r1v = 0;
    end

    // async reset with a write in flight and a pending bit set
    step(1, 5'd3, 64'hABCD, 0, 0, 0, 1, 5'd3, 0, 0, g);
    @(posedge clk);
    #2;
    req0_valid = 0; req1_valid = 0; claim_valid = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_we3", {63'd0, we3}, 64'd0);
    chk("async_pending", {33'd0, pending}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 1, 5'd9, 64'h99, 0, 0, 0, 0, g);
    step(1, 5'd4, 64'h44, 1, 5'd9, 64'h99, 0, 0, 0, 0, g);
    chk("post_reset_rr", g, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
